// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the execute stage and the HI/LO unit.
// The core drives the master side; the multiply/divide unit is the slave.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Sequential MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// HILO_FAST_MULT_EN selects a single-cycle array multiplier.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           div_q, div_d;
  logic           dz_q, dz_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   m_q, m_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   araw_q, araw_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic           sgn;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W:0]     sum;
  logic [W:0]     rem_sh;
  logic           ge;
  logic [2*W-1:0] prod;

  assign sgn   = ~bus.op[0];
  assign mag_a = (sgn & bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b = (sgn & bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;

  // Shift-add step: low half holds the remaining multiplier bits.
  assign sum = {1'b0, acc_q[2*W-1:W]}
             + (acc_q[0] ? {1'b0, m_q} : '0);

  // Restoring step: dividend bits shift out of the low half MSB first.
  assign rem_sh = {rem_q, acc_q[W-1]};
  assign ge     = rem_sh >= {1'b0, m_q};

  assign prod = qneg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dz_d    = dz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    m_d     = m_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b100: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            3'b000, 3'b001, 3'b010, 3'b011: begin
              div_d  = bus.op[1];
              dz_d   = 1'b0;
              qneg_d = sgn & (bus.a[W-1] ^ bus.b[W-1]);
              rneg_d = sgn & bus.a[W-1];
              araw_d = bus.a;
              cnt_d  = '0;
              rem_d  = '0;
              if (bus.op[1]) begin
                m_d   = mag_b;
                acc_d = {{W{1'b0}}, mag_a};
                if (bus.b == '0) begin
                  dz_d    = 1'b1;
                  state_d = S_FIX;
                end else begin
                  state_d = S_RUN;
                end
              end else begin
                m_d = mag_a;
`ifdef HILO_FAST_MULT_EN
                acc_d   = {{W{1'b0}}, mag_a}
                        * {{W{1'b0}}, mag_b};
                state_d = S_FIX;
`else
                acc_d   = {{W{1'b0}}, mag_b};
                state_d = S_RUN;
`endif
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 6'(W - 1)) state_d = S_FIX;
        if (div_q) begin
          if (ge) begin
            rem_d = W'(rem_sh - {1'b0, m_q});
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[W-1:0];
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[W-1:1]};
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else if (div_q) begin
          lo_d = qneg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
          hi_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
